// File: rtl/cmp_stream_tracker_if.sv
// Sample stream handshake into the comparator tracker.
// accept = in_valid & in_ready.
interface cmp_stream_tracker_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/cmp_stream_tracker.sv
// Windowed stream tracker: running max/min and up/down/equal
// step counts over WINDOW samples, done pulse per window.
module cmp_stream_tracker #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  cmp_stream_tracker_if.slave s,
  output logic [3:0]       max_out,
  output logic [3:0]       min_out,
  output logic [CNT_W-1:0] up_cnt,
  output logic [CNT_W-1:0] down_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             busy,
  output logic             done
);

  localparam int CW = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       max_q, max_d;
  logic [3:0]       min_q, min_d;
  logic [3:0]       prev_q, prev_d;
  logic [CNT_W-1:0] up_q, up_d;
  logic [CNT_W-1:0] down_q, down_d;
  logic [CNT_W-1:0] eq_q, eq_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic accept;
  logic gt_p, lt_p, gt_m, lt_m;

  // 2-level comparator: per-bit equality, then OR of prefix terms
  function automatic logic gt4(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] e;
    e = ~(a ^ b);
    return (a[3] & ~b[3])
         | (e[3] & a[2] & ~b[2])
         | (e[3] & e[2] & a[1] & ~b[1])
         | (e[3] & e[2] & e[1] & a[0] & ~b[0]);
  endfunction

  assign gt_p = gt4(s.in_data, prev_q);
  assign lt_p = gt4(prev_q, s.in_data);
  assign gt_m = gt4(s.in_data, max_q);
  assign lt_m = gt4(min_q, s.in_data);

  assign s.in_ready = (state_q != S_DONE);
  assign accept     = s.in_valid & s.in_ready;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    prev_d  = prev_q;
    up_d    = up_q;
    down_d  = down_q;
    eq_d    = eq_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          max_d   = s.in_data;
          min_d   = s.in_data;
          prev_d  = s.in_data;
          up_d    = '0;
          down_d  = '0;
          eq_d    = '0;
          cnt_d   = CW'(1);
          state_d = (WINDOW == 1) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (gt_p)      up_d   = up_q + CNT_W'(1);
          else if (lt_p) down_d = down_q + CNT_W'(1);
          else           eq_d   = eq_q + CNT_W'(1);
          if (gt_m) max_d = s.in_data;
          if (lt_m) min_d = s.in_data;
          prev_d = s.in_data;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_d == CW'(WINDOW)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort drops any coincident sample
    if (clear) begin
      state_d = S_IDLE;
      max_d   = '0;
      min_d   = '0;
      prev_d  = '0;
      up_d    = '0;
      down_d  = '0;
      eq_d    = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      max_q   <= '0;
      min_q   <= '0;
      prev_q  <= '0;
      up_q    <= '0;
      down_q  <= '0;
      eq_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      prev_q  <= prev_d;
      up_q    <= up_d;
      down_q  <= down_d;
      eq_q    <= eq_d;
      cnt_q   <= cnt_d;
    end
  end

  assign max_out  = max_q;
  assign min_out  = min_q;
  assign up_cnt   = up_q;
  assign down_cnt = down_q;
  assign eq_cnt   = eq_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Bench: WINDOW=8 and WINDOW=1 trackers on one stimulus stream,
// checked every cycle against a sample-list reference model.
module tb_cmp_stream_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       tv;
  logic [3:0] td;

  always #5 clk = ~clk;

  cmp_stream_tracker_if sif0 ();
  cmp_stream_tracker_if sif1 ();

  assign sif0.in_valid = tv;
  assign sif0.in_data  = td;
  assign sif1.in_valid = tv;
  assign sif1.in_data  = td;

  logic [3:0] max_o [2];
  logic [3:0] min_o [2];
  logic [3:0] up_o  [2];
  logic [3:0] dn_o  [2];
  logic [3:0] eq_o  [2];
  logic [1:0] busy_o, done_o, rdy_o;

  assign rdy_o[0] = sif0.in_ready;
  assign rdy_o[1] = sif1.in_ready;

  cmp_stream_tracker #(.WINDOW(8), .CNT_W(4)) u0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .s        (sif0),
    .max_out  (max_o[0]),
    .min_out  (min_o[0]),
    .up_cnt   (up_o[0]),
    .down_cnt (dn_o[0]),
    .eq_cnt   (eq_o[0]),
    .busy     (busy_o[0]),
    .done     (done_o[0])
  );

  cmp_stream_tracker #(.WINDOW(1), .CNT_W(4)) u1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .s        (sif1),
    .max_out  (max_o[1]),
    .min_out  (min_o[1]),
    .up_cnt   (up_o[1]),
    .down_cnt (dn_o[1]),
    .eq_cnt   (eq_o[1]),
    .busy     (busy_o[1]),
    .done     (done_o[1])
  );

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  // reference: list of window samples plus a phase (0 idle, 1 run, 2 done)
  int         ph [2];
  int         n  [2];
  logic [3:0] smp [2][16];

  function automatic int win(input int k);
    return (k == 0) ? 8 : 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic expect_of(input int k,
                           output int mx, output int mn,
                           output int up, output int dn,
                           output int eq);
    mx = 0; mn = 0; up = 0; dn = 0; eq = 0;
    if (n[k] > 0) begin
      mx = smp[k][0];
      mn = smp[k][0];
      for (int i = 1; i < n[k]; i++) begin
        if (smp[k][i] > mx) mx = smp[k][i];
        if (smp[k][i] < mn) mn = smp[k][i];
        if (smp[k][i] > smp[k][i-1])      up++;
        else if (smp[k][i] < smp[k][i-1]) dn++;
        else                              eq++;
      end
    end
  endtask

  task automatic mstep(input int k);
    if (!rst_n || clear) begin
      n[k]  = 0;
      ph[k] = 0;
    end else begin
      case (ph[k])
        0: if (tv) begin
          n[k]      = 1;
          smp[k][0] = td;
          ph[k]     = (n[k] == win(k)) ? 2 : 1;
        end
        1: if (tv) begin
          smp[k][n[k]] = td;
          n[k]++;
          if (n[k] == win(k)) ph[k] = 2;
        end
        default: ph[k] = 0;
      endcase
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0;
      n[k]  = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) armed = 1;
    for (int k = 0; k < 2; k++) mstep(k);
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        int mx, mn, up, dn, eq;
        expect_of(k, mx, mn, up, dn, eq);
        chk($sformatf("u%0d_max", k), max_o[k], mx);
        chk($sformatf("u%0d_min", k), min_o[k], mn);
        chk($sformatf("u%0d_up", k), up_o[k], up);
        chk($sformatf("u%0d_down", k), dn_o[k], dn);
        chk($sformatf("u%0d_eq", k), eq_o[k], eq);
        chk($sformatf("u%0d_ready", k), rdy_o[k], int'(ph[k] != 2));
        chk($sformatf("u%0d_busy", k), busy_o[k], int'(ph[k] == 1));
        chk($sformatf("u%0d_done", k), done_o[k], int'(ph[k] == 2));
        if (done_o[k])
          chk($sformatf("u%0d_step_sum", k),
              up_o[k] + dn_o[k] + eq_o[k], win(k) - 1);
      end
    end
  end

  task automatic cyc(input logic v, input logic [3:0] d,
                     input logic c, input logic r);
    @(posedge clk);
    #1;
    tv    = v;
    td    = d;
    clear = c;
    rst_n = r;
  endtask

  task automatic lit0(input string t, input int mx, input int mn,
                      input int up, input int dn, input int eq,
                      input int bz, input int dn_pulse, input int rdy);
    int emx, emn, eup, edn, eeq;
    chk({t, "_max"}, max_o[0], mx);
    chk({t, "_min"}, min_o[0], mn);
    chk({t, "_up"}, up_o[0], up);
    chk({t, "_down"}, dn_o[0], dn);
    chk({t, "_eq"}, eq_o[0], eq);
    chk({t, "_busy"}, busy_o[0], bz);
    chk({t, "_done"}, done_o[0], dn_pulse);
    chk({t, "_ready"}, rdy_o[0], rdy);
    expect_of(0, emx, emn, eup, edn, eeq);
    chk({t, "_model_max"}, emx, mx);
    chk({t, "_model_min"}, emn, mn);
    chk({t, "_model_steps"}, eup * 256 + edn * 16 + eeq,
        up * 256 + dn * 16 + eq);
  endtask

  logic [3:0] s2 [8];

  initial begin
    s2 = '{4'd3, 4'd5, 4'd5, 4'd2, 4'd9, 4'd9, 4'd1, 4'd4};
    rst_n = 1'b0;
    clear = 1'b0;
    tv    = 1'b0;
    td    = 4'd0;

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    @(negedge clk);
    lit0("reset", 0, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 8; i++) cyc(1, s2[i], 0, 1);
    cyc(0, 0, 0, 1);
    @(negedge clk);
    lit0("b2b", 9, 1, 3, 2, 2, 0, 1, 0);

    for (int i = 0; i < 8; i++) begin
      cyc(1, s2[i], 0, 1);
      cyc(0, 0, 0, 1);
    end
    @(negedge clk);
    lit0("gaps", 9, 1, 3, 2, 2, 0, 1, 0);

    for (int i = 0; i < 4; i++) cyc(1, s2[i], 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    @(negedge clk);
    lit0("clear", 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 4'd7, 0, 1);
    cyc(0, 0, 0, 1);
    @(negedge clk);
    lit0("sevens", 7, 7, 0, 0, 7, 0, 1, 0);

    for (int i = 0; i < 8; i++) cyc(1, 4'(i + 1), 0, 1);
    cyc(1, 4'd15, 0, 1);
    @(negedge clk);
    lit0("held_done", 8, 1, 7, 0, 0, 0, 1, 0);
    cyc(1, 4'd15, 0, 1);
    cyc(0, 0, 0, 1);
    @(negedge clk);
    lit0("held_next", 15, 15, 0, 0, 0, 1, 0, 1);

    cyc(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1, 4'(2 * i), 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    @(negedge clk);
    lit0("mid_rst", 0, 0, 0, 0, 0, 0, 0, 1);

    cyc(1, 4'd6, 0, 1);
    cyc(0, 0, 0, 1);
    @(negedge clk);
    chk("w1_done", done_o[1], 1);
    chk("w1_max", max_o[1], 6);
    chk("w1_min", min_o[1], 6);
    chk("w1_steps", up_o[1] + dn_o[1] + eq_o[1], 0);
    chk("w1_ready", rdy_o[1], 0);

    for (int i = 0; i < 3000; i++) begin
      int         r;
      logic [3:0] d;
      r = $urandom_range(0, 999);
      case ($urandom_range(0, 9))
        0:       d = 4'd0;
        1:       d = 4'd15;
        default: d = 4'($urandom_range(0, 15));
      endcase
      cyc(logic'($urandom_range(0, 9) < 7), d,
          logic'(r >= 5 && r < 25), logic'(r >= 5));
    end
    cyc(0, 0, 0, 1);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
